// File: rtl/appr_stats_pkg.sv
// Shared widths, FSM state type and saturating-add helpers for the approximate-adder error statistics block.
package appr_stats_pkg;

  localparam int DEF_W     = 24;
  localparam int DEF_EW    = DEF_W + 2;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_SUM_W = 64;
  localparam int DEF_SQ_W  = 80;
  localparam int MAXW      = 128;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef logic signed [MAXW-1:0] wide_s_t;
  typedef logic [MAXW-1:0]        wide_u_t;

  // Helpers work at MAXW and clamp to a w-bit range; callers narrow the result.
  function automatic wide_s_t s_max(input int w);
    return wide_s_t'((wide_u_t'(1) << (w - 1)) - wide_u_t'(1));
  endfunction

  function automatic wide_s_t s_min(input int w);
    return ~s_max(w);
  endfunction

  function automatic wide_u_t u_max(input int w);
    return (wide_u_t'(1) << w) - wide_u_t'(1);
  endfunction

  function automatic logic ovf_add_s(input wide_s_t a, input wide_s_t b, input int w);
    wide_s_t s;
    s = a + b;
    return (s > s_max(w)) || (s < s_min(w));
  endfunction

  function automatic wide_s_t sat_add_s(input wide_s_t a, input wide_s_t b, input int w);
    wide_s_t s;
    s = a + b;
    if (s > s_max(w)) return s_max(w);
    if (s < s_min(w)) return s_min(w);
    return s;
  endfunction

  function automatic logic ovf_add_u(input wide_u_t a, input wide_u_t b, input int w);
    wide_u_t s;
    s = a + b;
    return s > u_max(w);
  endfunction

  function automatic wide_u_t sat_add_u(input wide_u_t a, input wide_u_t b, input int w);
    wide_u_t s;
    s = a + b;
    if (s > u_max(w)) return u_max(w);
    return s;
  endfunction

endpackage

// File: rtl/appr_err_calc.sv
// Stage 1 of the error-statistics pipeline: registered signed error, its magnitude and a nonzero flag.
module appr_err_calc
  import appr_stats_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld_p0,
  input  logic [W:0]           exact_sum,
  input  logic [W:0]           appr_sum,
  output logic                 vld_p1,
  output logic signed [W+1:0]  err_p1,
  output logic [W+1:0]         abs_p1,
  output logic                 nz_p1
);

  localparam int EW = W + 2;

  logic signed [EW-1:0] err_p0;
  logic [EW-1:0]        abs_p0;

  // Both sums are treated as signed W+1-bit values; their difference always fits EW bits.
  always_comb begin
    err_p0 = EW'($signed(appr_sum)) - EW'($signed(exact_sum));
    abs_p0 = err_p0[EW-1] ? EW'(-err_p0) : EW'(err_p0);
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      err_p1 <= err_p0;
      abs_p1 <= abs_p0;
      nz_p1  <= |err_p0;
    end
  end

endmodule

// File: rtl/appr_err_stats.sv
// Error statistics accumulator for exact vs approximate adder sums: FSM, sample counters and stage-2 accumulation.
// Define APPR_STATS_SQ_EN to build the squared-error path; otherwise err_sq_sum reads zero.
module appr_err_stats
  import appr_stats_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SUM_W = DEF_SUM_W,
  parameter int SQ_W  = DEF_SQ_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        target,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W:0]              exact_sum,
  input  logic [W:0]              appr_sum,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        sample_count,
  output logic signed [SUM_W-1:0] err_sum,
  output logic [SQ_W-1:0]         err_sq_sum,
  output logic [W+1:0]            max_abs_err,
  output logic [CNT_W-1:0]        nz_count,
  output logic                    ovf
);

  localparam int EW = W + 2;

  state_t                  state_q, state_nxt;
  logic [CNT_W-1:0]        target_q, accepted_q;
  logic                    start_go, vld_p0, vld_p1, nz_p1;
  logic signed [EW-1:0]    err_p1;
  logic [EW-1:0]           abs_p1;
  logic signed [SUM_W-1:0] sum_nxt;
  logic [CNT_W-1:0]        cnt_nxt, nz_nxt;
  logic [EW-1:0]           max_nxt;
  logic                    ovf_nxt, sq_ovf;

  assign start_go = start && (state_q != S_RUN);
  assign vld_p0   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  // Leave RUN only once every accepted sample has drained out of stage 1.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if ((accepted_q == target_q) && !vld_p1) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == S_RUN);
    done     = (state_q == S_DONE);
    in_ready = busy && (accepted_q < target_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accepted_q <= '0;
      target_q   <= '0;
    end else if (start_go) begin
      accepted_q <= '0;
      target_q   <= target;
    end else if (vld_p0) begin
      accepted_q <= accepted_q + CNT_W'(1);
    end
  end

  // Stage 0 -> 1 boundary
  appr_err_calc #(.W(W)) u_calc (
    .clk       (clk),
    .rst       (rst),
    .vld_p0    (vld_p0),
    .exact_sum (exact_sum),
    .appr_sum  (appr_sum),
    .vld_p1    (vld_p1),
    .err_p1    (err_p1),
    .abs_p1    (abs_p1),
    .nz_p1     (nz_p1)
  );

  // Stage 1 -> 2 boundary
  always_comb begin
    sum_nxt = SUM_W'(sat_add_s(MAXW'(err_sum), MAXW'(err_p1), SUM_W));
    cnt_nxt = CNT_W'(sat_add_u(MAXW'(sample_count), MAXW'(1), CNT_W));
    nz_nxt  = CNT_W'(sat_add_u(MAXW'(nz_count), MAXW'(nz_p1), CNT_W));
    max_nxt = (abs_p1 > max_abs_err) ? abs_p1 : max_abs_err;
    ovf_nxt = ovf
            | ovf_add_s(MAXW'(err_sum), MAXW'(err_p1), SUM_W)
            | ovf_add_u(MAXW'(sample_count), MAXW'(1), CNT_W)
            | ovf_add_u(MAXW'(nz_count), MAXW'(nz_p1), CNT_W)
            | sq_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      sample_count <= '0;
      err_sum      <= '0;
      max_abs_err  <= '0;
      nz_count     <= '0;
      ovf          <= 1'b0;
    end else if (vld_p1) begin
      sample_count <= cnt_nxt;
      err_sum      <= sum_nxt;
      max_abs_err  <= max_nxt;
      nz_count     <= nz_nxt;
      ovf          <= ovf_nxt;
    end
  end

`ifdef APPR_STATS_SQ_EN
  logic signed [2*EW-1:0] err_sq;
  logic [SQ_W-1:0]        sq_nxt;

  always_comb begin
    err_sq = (2*EW)'(err_p1) * (2*EW)'(err_p1);
    sq_nxt = SQ_W'(sat_add_u(MAXW'(err_sq_sum), MAXW'($unsigned(err_sq)), SQ_W));
    sq_ovf = ovf_add_u(MAXW'(err_sq_sum), MAXW'($unsigned(err_sq)), SQ_W);
  end

  always_ff @(posedge clk) begin
    if (rst || start_go) err_sq_sum <= '0;
    else if (vld_p1)     err_sq_sum <= sq_nxt;
  end
`else
  assign err_sq_sum = '0;
  assign sq_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_appr_err_stats.sv
// Scoreboard bench for appr_err_stats: directed corner cases plus a long random run against a behavioural model.
module tb_appr_err_stats;

  localparam int W     = 24;
  localparam int EW    = W + 2;
  localparam int CNT_W = 32;
  localparam int SUM_W = 64;
  localparam int SQ_W  = 80;

  localparam logic signed [127:0] SMAX = (128'sd1 <<< (SUM_W - 1)) - 128'sd1;
  localparam logic signed [127:0] SMIN = -SMAX - 128'sd1;
  localparam logic [127:0]        QMAX = (128'd1 << SQ_W) - 128'd1;

`ifdef APPR_STATS_SQ_EN
  localparam logic [127:0] SQ_T2 = 128'd290;
  localparam logic [127:0] SQ_T5 = 128'd2000;
`else
  localparam logic [127:0] SQ_T2 = 128'd0;
  localparam logic [127:0] SQ_T5 = 128'd0;
`endif

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [CNT_W-1:0] target = '0;
  logic [W:0] exact_sum = '0, appr_sum = '0;

  logic in_ready, busy, done, ovf;
  logic [CNT_W-1:0] sample_count, nz_count;
  logic signed [SUM_W-1:0] err_sum;
  logic [SQ_W-1:0] err_sq_sum;
  logic [EW-1:0] max_abs_err;

  logic x8_in_ready, x8_busy, x8_done, x8_ovf;
  logic [CNT_W-1:0] x8_sample_count, x8_nz_count;
  logic signed [7:0] x8_err_sum;
  logic [SQ_W-1:0] x8_err_sq_sum;
  logic [EW-1:0] x8_max_abs_err;

  int n_chk = 0, n_pass = 0, xfer_cnt = 0;

  typedef struct {
    logic [CNT_W-1:0]        cnt;
    logic signed [SUM_W-1:0] sum;
    logic [SQ_W-1:0]         sq;
    logic [EW-1:0]           mx;
    logic [CNT_W-1:0]        nz;
    logic                    ovf;
  } exp_t;
  exp_t sb_q[$];

  logic signed [127:0] m_sum, m_max;
  logic [127:0] m_sq;
  logic [CNT_W-1:0] m_cnt, m_nz;
  logic m_ovf;
  logic pend1 = 1'b0, pend2 = 1'b0;

  appr_err_stats dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .in_valid(in_valid), .in_ready(in_ready),
    .exact_sum(exact_sum), .appr_sum(appr_sum), .busy(busy), .done(done), .sample_count(sample_count),
    .err_sum(err_sum), .err_sq_sum(err_sq_sum), .max_abs_err(max_abs_err), .nz_count(nz_count), .ovf(ovf)
  );

  appr_err_stats #(.SUM_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .target(target), .in_valid(in_valid), .in_ready(x8_in_ready),
    .exact_sum(exact_sum), .appr_sum(appr_sum), .busy(x8_busy), .done(x8_done),
    .sample_count(x8_sample_count), .err_sum(x8_err_sum), .err_sq_sum(x8_err_sq_sum),
    .max_abs_err(x8_max_abs_err), .nz_count(x8_nz_count), .ovf(x8_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [127:0] got, input logic signed [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic model_clear();
    m_sum = '0; m_max = '0; m_sq = '0; m_cnt = '0; m_nz = '0; m_ovf = 1'b0;
  endtask

  // Model updates on every observed transfer; DUT results appear two negedges later.
  always @(negedge clk) begin
    exp_t x;
    logic signed [127:0] e, ae;
    if (rst) begin
      sb_q.delete();
      pend1 = 1'b0;
      pend2 = 1'b0;
      model_clear();
    end else begin
      if (pend2) begin
        if (sb_q.size() == 0) check_eq("sb_underflow", 1, 0);
        else begin
          x = sb_q.pop_front();
          check_eq("sb_count", sample_count, x.cnt);
          check_eq("sb_err_sum", err_sum, x.sum);
          check_eq("sb_err_sq_sum", err_sq_sum, x.sq);
          check_eq("sb_max_abs", max_abs_err, x.mx);
          check_eq("sb_nz_count", nz_count, x.nz);
          check_eq("sb_ovf", ovf, x.ovf);
        end
      end
      pend2 = pend1;
      pend1 = 1'b0;
      if (start && !busy) model_clear();
      if (in_valid && in_ready) begin
        e = 128'($signed(appr_sum)) - 128'($signed(exact_sum));
        ae = (e < 0) ? -e : e;
        m_cnt = m_cnt + 1;
        m_sum = m_sum + e;
        if (m_sum > SMAX) begin m_sum = SMAX; m_ovf = 1'b1; end
        else if (m_sum < SMIN) begin m_sum = SMIN; m_ovf = 1'b1; end
`ifdef APPR_STATS_SQ_EN
        m_sq = m_sq + e * e;
        if (m_sq > QMAX) begin m_sq = QMAX; m_ovf = 1'b1; end
`endif
        if (ae > m_max) m_max = ae;
        if (e != 0) m_nz = m_nz + 1;
        x.cnt = m_cnt; x.sum = m_sum[SUM_W-1:0]; x.sq = m_sq[SQ_W-1:0];
        x.mx = m_max[EW-1:0]; x.nz = m_nz; x.ovf = m_ovf;
        sb_q.push_back(x);
        pend1 = 1'b1;
        xfer_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] t);
    start = 1'b1;
    target = t;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [W:0] ex, input logic [W:0] ap);
    in_valid = 1'b1;
    exact_sum = ex;
    appr_sum = ap;
    for (int k = 0; k < 50 && !in_ready; k++) tick();
    check_eq("send_ready", in_ready, 1);
    tick();
  endtask

  task automatic wait_done(input int limit);
    for (int k = 0; k < limit && !done; k++) tick();
    check_eq("wait_done", done, 1);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_cnt"}, sample_count, 0);
    check_eq({tag, "_sum"}, err_sum, 0);
    check_eq({tag, "_sq"}, err_sq_sum, 0);
    check_eq({tag, "_max"}, max_abs_err, 0);
    check_eq({tag, "_nz"}, nz_count, 0);
    check_eq({tag, "_ovf"}, ovf, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_ready"}, in_ready, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W:0] ex, ap;
    repeat (3) tick();
    check_zero("rst");
    rst = 1'b0;
    tick();

    // reset in the middle of a run
    do_start(10);
    for (int i = 0; i < 5; i++) send(W'(i * 3), W'(i * 3 + 1));
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("mid_rst");
    tick();
    check_eq("mid_rst_idle", busy, 0);

    // four directed pairs
    do_start(4);
    send(100, 100);
    send(100, 96);
    send(200, 207);
    send(25'h1FFFFFF, 25'h1FFFFF0);
    in_valid = 1'b0;
    check_eq("t2_done_c1", done, 0);
    tick();
    check_eq("t2_done_c2", done, 0);
    check_eq("t2_err_sum", err_sum, -12);
    check_eq("t2_err_sq", err_sq_sum, SQ_T2);
    check_eq("t2_max", max_abs_err, 15);
    check_eq("t2_nz", nz_count, 3);
    check_eq("t2_cnt", sample_count, 4);
    tick();
    check_eq("t2_done_c3", done, 1);
    check_eq("t2_busy", busy, 0);

    // zero-length run
    do_start(0);
    check_eq("t3_busy", busy, 1);
    check_eq("t3_ready1", in_ready, 0);
    check_eq("t3_done1", done, 0);
    tick();
    check_eq("t3_ready2", in_ready, 0);
    check_eq("t3_done2", done, 1);
    check_eq("t3_cnt", sample_count, 0);
    check_eq("t3_sum", err_sum, 0);
    check_eq("t3_max", max_abs_err, 0);

    // in_valid held high; a start during RUN must not restart
    xfer_cnt = 0;
    in_valid = 1'b1;
    exact_sum = 1000;
    appr_sum = 1003;
    do_start(3);
    check_eq("t4_ready1", in_ready, 1);
    start = 1'b1;
    target = 100;
    tick();
    start = 1'b0;
    check_eq("t4_ready2", in_ready, 1);
    tick();
    check_eq("t4_ready3", in_ready, 1);
    tick();
    check_eq("t4_ready_drop", in_ready, 0);
    check_eq("t4_busy", busy, 1);
    repeat (3) tick();
    in_valid = 1'b0;
    wait_done(20);
    check_eq("t4_xfers", xfer_cnt, 3);
    check_eq("t4_cnt", sample_count, 3);
    check_eq("t4_sum", err_sum, 9);

    // 8-bit error sum saturates
    do_start(20);
    for (int i = 0; i < 20; i++) send(0, 10);
    in_valid = 1'b0;
    wait_done(20);
    check_eq("t5_sum8", x8_err_sum, 127);
    check_eq("t5_ovf8", x8_ovf, 1);
    check_eq("t5_cnt8", x8_sample_count, 20);
    check_eq("t5_nz8", x8_nz_count, 20);
    check_eq("t5_max8", x8_max_abs_err, 10);
    check_eq("t5_sq8", x8_err_sq_sum, SQ_T5);
    check_eq("t5_done8", x8_done, 1);
    check_eq("t5_busy8", x8_busy, 0);
    check_eq("t5_ready8", x8_in_ready, 0);
    check_eq("t5_sum64", err_sum, 200);
    check_eq("t5_ovf64", ovf, 0);
    repeat (3) tick();
    check_eq("t5_ovf_sticky", x8_ovf, 1);
    do_start(1);
    check_eq("t5_ovf_clr", x8_ovf, 0);
    check_eq("t5_sum_clr", x8_err_sum, 0);
    send(5, 5);
    in_valid = 1'b0;
    wait_done(20);

    // long random run including extreme operands
    do_start(10000);
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      ex = (W+1)'($urandom);
      case ($urandom_range(0, 4))
        0: ap = ex;
        1: ap = (W+1)'($urandom);
        2: begin ex = 25'h1000000; ap = 25'h0FFFFFF; end
        default: ap = ex + (W+1)'($urandom_range(0, 80)) - (W+1)'(40);
      endcase
      send(ex, ap);
    end
    in_valid = 1'b0;
    wait_done(50);
    check_eq("t6_cnt", sample_count, 10000);
    check_eq("t6_max", max_abs_err, 26'h1FFFFFF);

    repeat (3) tick();
    check_eq("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
